// File: rtl/wb_select_seq_if.sv
// wb_select_seq_if: request/source/write-back bundle for wb_select_seq.
//   master : requester and result producers (drives start, seletor, dest_addr,
//            src_data, src_ready; observes the write-back outputs)
//   slave  : the selector itself
interface wb_select_seq_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned ADDR_W = 5
);
    localparam int unsigned N_SRC = 2 ** SEL_W;

    logic                      start;
    logic [SEL_W-1:0]          seletor;
    logic [ADDR_W-1:0]         dest_addr;
    logic [N_SRC*DATA_W-1:0]   src_data;
    logic [N_SRC-1:0]          src_ready;
    logic [DATA_W-1:0]         wb_data;
    logic [ADDR_W-1:0]         wb_addr;
    logic                      reg_write;
    logic                      done;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        output start, seletor, dest_addr, src_data, src_ready,
        input  wb_data, wb_addr, reg_write, done, busy, timeout_err
    );

    modport slave (
        input  start, seletor, dest_addr, src_data, src_ready,
        output wb_data, wb_addr, reg_write, done, busy, timeout_err
    );
endinterface

// File: rtl/wb_select_seq.sv
// wb_select_seq: sequential write-back source selector.
// Accepts a request (source index + destination), waits for the selected
// source to be ready (bounded by TIMEOUT), latches its word and issues a
// one-cycle register-file write strobe.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : wb_select_seq_if.slave (request, sources, write-back outputs)
module wb_select_seq #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned CONST_IDX = 0,
    parameter int unsigned CONST_VAL = 227,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic           clk,
    input  logic           reset,
    wb_select_seq_if.slave bus
);
    localparam int unsigned N_SRC  = 2 ** SEL_W;
    localparam int unsigned CNT_W  = 8;
    localparam bit          TO_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]  TO_LAST    = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] CONST_WORD = DATA_W'(CONST_VAL);
    localparam logic [SEL_W-1:0]  CONST_SEL  = SEL_W'(CONST_IDX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
    logic               reg_write_q, reg_write_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               terr_q, terr_d;

    logic [DATA_W-1:0]  sel_word;
    logic               sel_ready;

    // Source mux; the constant slot overrides its data and ready inputs
    always_comb begin
        sel_word  = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_word  = bus.src_data[i*DATA_W +: DATA_W];
                sel_ready = bus.src_ready[i];
            end
        end
        if (sel_q == CONST_SEL) begin
            sel_word  = CONST_WORD;
            sel_ready = 1'b1;
        end
    end

    // Next-state and registered-output logic; strobes are computed one cycle
    // early so reg_write/done line up with the WRITE cycle (or abort cycle)
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        wb_data_d   = wb_data_q;
        wb_addr_d   = wb_addr_q;
        terr_d      = terr_q;
        reg_write_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sel_d     = bus.seletor;
                    wb_addr_d = bus.dest_addr;
                    cnt_d     = '0;
                    terr_d    = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sel_ready) begin
                    wb_data_d   = sel_word;
                    reg_write_d = (wb_addr_q != '0);
                    done_d      = 1'b1;
                    state_d     = S_WRITE;
                end else if (TO_EN) begin
                    if (cnt_q == TO_LAST) begin
                        terr_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            wb_data_q   <= '0;
            wb_addr_q   <= '0;
            reg_write_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            wb_data_q   <= wb_data_d;
            wb_addr_q   <= wb_addr_d;
            reg_write_q <= reg_write_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
        end
    end

    assign bus.wb_data     = wb_data_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: doc/wb_select_seq.md
# wb_select_seq

Sequential, parametrised write-back source selector for the multicycle datapath. It accepts a write-back request naming a source index and a destination register. It waits until the selected source reports ready, or aborts after a bounded wait. It then latches the selected word and issues a single-cycle register-file write strobe. It sits between the result producers (ALUOut, memory, MDR, HI/LO, shifter, PC+4, constant) and the register-file write port, and replaces the purely combinational write-data mux.

## Interface
Parameters:
- DATA_W, 32, width of every source word and of wb_data
- SEL_W, 3, selector width; number of sources N_SRC = 2**SEL_W
- ADDR_W, 5, register-file address width
- CONST_IDX, 0, source index that yields the constant CONST_VAL and is always ready
- CONST_VAL, 227, constant returned for CONST_IDX (truncated to DATA_W)
- TIMEOUT, 15, maximum WAIT cycles before abort (range 0..255); 0 disables the timeout

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values
- start  in  1  request strobe, sampled only in IDLE
- seletor  in  SEL_W  source index for the request
- dest_addr  in  ADDR_W  destination register for the request
- src_data  in  N_SRC*DATA_W  flattened sources; source i occupies bits [i*DATA_W +: DATA_W]; the slice at CONST_IDX is ignored
- src_ready  in  N_SRC  per-source ready; the bit at CONST_IDX is ignored (treated as 1)
- wb_data  out  DATA_W  latched write data
- wb_addr  out  ADDR_W  latched destination
- reg_write  out  1  one-cycle register-file write strobe
- done  out  1  one-cycle completion pulse (write or abort)
- busy  out  1  high while a request is in flight
- timeout_err  out  1  sticky abort flag

## Operation
- States: IDLE, WAIT, WRITE.
- IDLE:
  - start=1 latches seletor into sel_q and dest_addr into wb_addr.
  - The wait counter clears, timeout_err clears, and the next state is WAIT.
  - start=0 holds IDLE.
- WAIT, when the selected source is ready (src_ready[sel_q]=1, or sel_q==CONST_IDX):
  - wb_data latches the selected word (CONST_VAL for CONST_IDX).
  - The next state is WRITE.
- WAIT, when the source is not ready and TIMEOUT≠0:
  - If the counter equals TIMEOUT-1, timeout_err is set, done pulses in the next cycle, and the next state is IDLE.
  - Otherwise the counter increments.
- WAIT, when TIMEOUT=0: the block waits indefinitely.
- Ready has priority over timeout in the same cycle.
- WRITE:
  - reg_write=1 for this cycle only if wb_addr≠0. Writes to register 0 are suppressed.
  - done=1 for this cycle regardless of address.
  - The next state is IDLE.
- busy=1 in WAIT and WRITE.
- start while busy is ignored: no queuing and no effect on latched fields.
- seletor and dest_addr changes after acceptance have no effect.
- src_data is sampled only in the WAIT cycle where ready is seen.
- wb_data and wb_addr hold their values until the next acceptance or capture.
- timeout_err stays high until the next accepted start or reset.
- An out-of-range seletor is impossible because N_SRC = 2**SEL_W.

## Timing
- Reset (async assert, sync-safe deassert):
  - State is IDLE.
  - wb_data, wb_addr, reg_write, done, busy and timeout_err are all 0.
  - The counter is 0.
- Reset in WAIT or WRITE aborts the request, with no reg_write and no done.
- Best-case latency: start sampled at edge k; WAIT during cycle k+1 with ready; reg_write and done high during cycle k+2.
- If ready first appears in WAIT cycle m (1-based), reg_write is high in cycle k+1+m.
- Abort: with ready never asserted, the block spends exactly TIMEOUT cycles in WAIT. done and timeout_err rise in the following cycle, with reg_write=0.
- A new start is accepted in the cycle after done; the back-to-back throughput is one request per 3 cycles.

## Test plan
- Constant path:
  - Stimulus: start with seletor=0, dest_addr=8, all src_ready=0.
  - Response: wb_data=227, wb_addr=8, and reg_write and done high exactly 2 cycles after start.
- Ready source:
  - Stimulus: seletor=1, slice1=0xDEADBEEF, src_ready[1]=1, dest_addr=3.
  - Response: reg_write in cycle k+2 with wb_data=0xDEADBEEF; busy high for 2 cycles.
- Delayed ready with data change:
  - Stimulus: seletor=4; src_ready[4] rises 5 cycles after start; slice4=0x1234 while not ready, 0xABCD when ready.
  - Response: reg_write in cycle k+6 with wb_data=0xABCD; timeout_err stays 0.
- Timeout:
  - Stimulus: TIMEOUT=15, seletor=5, ready never asserted.
  - Response: done and timeout_err after 15 WAIT cycles with reg_write never asserted.
  - Follow-up: the next start clears timeout_err.
- Register 0 and ignored start:
  - Stimulus: dest_addr=0 with seletor=7 ready; a second start with dest_addr=9 during WAIT.
  - Response: done pulses, reg_write stays 0, and wb_addr remains 0.
- Reset mid-WAIT:
  - Stimulus: assert reset asynchronously (between edges) during WAIT.
  - Response: all outputs 0 immediately; no reg_write or done after deassert; a new request completes normally.
